// File: rtl/ant_path_sequencer.sv
// rtl/ant_path_sequencer.sv - move history stack and trip sequencer for one forager ant
module ant_path_sequencer #(
    parameter int W     = 3,
    parameter int DEPTH = 32,
    parameter int DW    = 6
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Start,
    input  logic          Abort,
    input  logic          MoveValid,
    input  logic [W-1:0]  MoveIn,
    input  logic          FoodFound,
    input  logic          MoveReady,
    output logic          MoveOutValid,
    output logic [W-1:0]  MoveOut,
    output logic          Busy,
    output logic          Returning,
    output logic [DW-1:0] Depth,
    output logic          Full,
    output logic          Overflow,
    output logic          Done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPLORE,
        ST_RETURN,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          overflow_q, overflow_d;
    logic          push;
    logic          full;
    logic          empty;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;
    logic [W-1:0]  top_move;
    logic [W-1:0]  stack_mem [DEPTH];

    assign full     = (depth_q == DW'(DEPTH));
    assign empty    = (depth_q == '0);
    assign wr_idx   = AW'(depth_q);
    assign top_idx  = AW'(depth_q - DW'(1));
    assign top_move = stack_mem[top_idx];

    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        if (Abort) begin
            state_d = ST_IDLE;
            depth_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        state_d    = ST_EXPLORE;
                        depth_d    = '0;
                        overflow_d = 1'b0;
                    end
                end
                ST_EXPLORE: begin
                    if (MoveValid) begin
                        if (full) begin
                            overflow_d = 1'b1;
                        end else begin
                            push    = 1'b1;
                            depth_d = depth_q + DW'(1);
                        end
                    end
                    if (FoodFound) begin
                        state_d = ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    // Popping the last entry goes straight to DONE so the pulse lands on the next cycle.
                    if (empty) begin
                        state_d = ST_DONE;
                    end else if (MoveReady) begin
                        depth_d = depth_q - DW'(1);
                        if (depth_q == DW'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            depth_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            stack_mem[wr_idx] <= MoveIn;
        end
    end

    assign Returning    = (state_q == ST_RETURN);
    assign Busy         = (state_q == ST_EXPLORE) || (state_q == ST_RETURN);
    assign Done         = (state_q == ST_DONE);
    assign MoveOutValid = Returning && !empty;
    // Opposite direction is half a turn away: add 4 and let the carry fall off.
    assign MoveOut      = MoveOutValid ? (top_move + W'(4)) : '0;
    assign Depth        = depth_q;
    assign Full         = full;
    assign Overflow     = overflow_q;

endmodule

// File: tb/tb_ant_path_sequencer.sv
// tb/tb_ant_path_sequencer.sv - randomized self-checking bench for ant_path_sequencer
module tb_ant_path_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort_i = 1'b0;
    logic       move_valid = 1'b0;
    logic [2:0] move_in = 3'd0;
    logic       food_found = 1'b0;
    logic       move_ready = 1'b0;
    logic       move_out_valid;
    logic [2:0] move_out;
    logic       busy;
    logic       returning;
    logic [5:0] depth;
    logic       full;
    logic       overflow;
    logic       done;

    int total = 0;
    int bad = 0;

    int stk[$];
    bit m_ovf = 1'b0;

    ant_path_sequencer #(.W(3), .DEPTH(32), .DW(6)) dut (
        .Clk(clk), .Rst_n(rst_n), .Start(start), .Abort(abort_i),
        .MoveValid(move_valid), .MoveIn(move_in), .FoodFound(food_found),
        .MoveReady(move_ready), .MoveOutValid(move_out_valid), .MoveOut(move_out),
        .Busy(busy), .Returning(returning), .Depth(depth), .Full(full),
        .Overflow(overflow), .Done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_trip();
        start = 1'b1;
        tick();
        start = 1'b0;
        stk.delete();
        m_ovf = 1'b0;
    endtask

    task automatic push_move(input logic [2:0] m);
        move_valid = 1'b1;
        move_in = m;
        tick();
        move_valid = 1'b0;
        if (stk.size() < 32) stk.push_back(int'(m));
        else m_ovf = 1'b1;
    endtask

    task automatic drain(output int emitted);
        int cyc;
        int expv;
        cyc = 0;
        emitted = 0;
        if (stk.size() == 0) tick();
        while (stk.size() > 0 && cyc < 500) begin
            move_ready = ($urandom_range(0, 3) != 0);
            expv = (stk[$] + 4) % 8;
            total++;
            if (move_out_valid !== 1'b1 || int'(move_out) !== expv || int'(depth) !== stk.size()) begin
                bad++;
                $display("FAIL drain_move: valid=%0b out=%0d depth=%0d required valid=1 out=%0d depth=%0d",
                         move_out_valid, move_out, depth, expv, stk.size());
            end
            tick();
            cyc++;
            if (move_ready) begin
                void'(stk.pop_back());
                emitted++;
            end
        end
        move_ready = 1'b0;
        total++;
        if (cyc >= 500 || done !== 1'b1 || depth !== 6'd0 || move_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_done: done=%0b depth=%0d valid=%0b cycles=%0d required done=1 depth=0 valid=0",
                     done, depth, move_out_valid, cyc);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL drain_idle: done=%0b busy=%0b required 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({move_out_valid, busy, returning, full, overflow, done} !== 6'b0 || depth !== 6'd0 || move_out !== 3'd0) begin
            bad++;
            $display("FAIL reset: v=%0b b=%0b r=%0b f=%0b o=%0b d=%0b depth=%0d out=%0d required all 0",
                     move_out_valid, busy, returning, full, overflow, done, depth, move_out);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%0b done=%0b required 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int exp_seq[3] = '{4, 6, 6};
        begin_trip();
        total++;
        if (busy !== 1'b1 || returning !== 1'b0 || depth !== 6'd0) begin
            bad++;
            $display("FAIL basic_explore: busy=%0b ret=%0b depth=%0d required 1 0 0", busy, returning, depth);
        end
        push_move(3'd2);
        push_move(3'd2);
        push_move(3'd0);
        total++;
        if (depth !== 6'd3) begin
            bad++;
            $display("FAIL basic_depth: depth=%0d required 3", depth);
        end
        food_found = 1'b1;
        move_ready = 1'b1;
        tick();
        food_found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (move_out_valid !== 1'b1 || int'(move_out) !== exp_seq[i] || returning !== 1'b1) begin
                bad++;
                $display("FAIL basic_pop%0d: valid=%0b out=%0d ret=%0b required 1 %0d 1",
                         i, move_out_valid, move_out, returning, exp_seq[i]);
            end
            tick();
        end
        move_ready = 1'b0;
        total++;
        if (done !== 1'b1 || depth !== 6'd0) begin
            bad++;
            $display("FAIL basic_done: done=%0b depth=%0d required 1 0", done, depth);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || depth !== 6'd0) begin
            bad++;
            $display("FAIL basic_idle: done=%0b busy=%0b depth=%0d required 0 0 0", done, busy, depth);
        end
    endtask

    task automatic test_full_overflow();
        int n;
        int first_exp;
        begin_trip();
        for (int i = 0; i < 32; i++) push_move(3'($urandom_range(0, 7)));
        total++;
        if (full !== 1'b1 || depth !== 6'd32 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL full_at32: full=%0b depth=%0d ovf=%0b required 1 32 0", full, depth, overflow);
        end
        push_move(3'($urandom_range(0, 7)));
        total++;
        if (full !== 1'b1 || depth !== 6'd32 || overflow !== 1'b1 || m_ovf !== 1'b1) begin
            bad++;
            $display("FAIL full_overflow: full=%0b depth=%0d ovf=%0b required 1 32 1", full, depth, overflow);
        end
        first_exp = (stk[31] + 4) % 8;
        food_found = 1'b1;
        tick();
        food_found = 1'b0;
        total++;
        if (int'(move_out) !== first_exp) begin
            bad++;
            $display("FAIL full_first_out: out=%0d required %0d", move_out, first_exp);
        end
        drain(n);
        total++;
        if (n !== 32) begin
            bad++;
            $display("FAIL full_count: emitted=%0d required 32", n);
        end
    endtask

    task automatic test_backpressure();
        int expv;
        int n;
        begin_trip();
        for (int i = 0; i < 3; i++) push_move(3'($urandom_range(0, 7)));
        food_found = 1'b1;
        move_ready = 1'b0;
        tick();
        food_found = 1'b0;
        expv = (stk[$] + 4) % 8;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (move_out_valid !== 1'b1 || int'(move_out) !== expv || depth !== 6'd3) begin
                bad++;
                $display("FAIL bp_hold%0d: valid=%0b out=%0d depth=%0d required 1 %0d 3",
                         i, move_out_valid, move_out, depth, expv);
            end
            tick();
        end
        move_ready = 1'b1;
        tick();
        void'(stk.pop_back());
        total++;
        if (depth !== 6'd2) begin
            bad++;
            $display("FAIL bp_pop: depth=%0d required 2", depth);
        end
        drain(n);
    endtask

    task automatic test_same_cycle();
        int n;
        begin_trip();
        push_move(3'($urandom_range(0, 7)));
        push_move(3'($urandom_range(0, 7)));
        food_found = 1'b1;
        push_move(3'd7);
        food_found = 1'b0;
        total++;
        if (depth !== 6'd3 || returning !== 1'b1 || move_out !== 3'd3) begin
            bad++;
            $display("FAIL same_cycle: depth=%0d ret=%0b out=%0d required 3 1 3", depth, returning, move_out);
        end
        drain(n);
    endtask

    task automatic test_empty_return();
        begin_trip();
        food_found = 1'b1;
        tick();
        food_found = 1'b0;
        total++;
        if (returning !== 1'b1 || move_out_valid !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL empty_ret: ret=%0b valid=%0b done=%0b required 1 0 0", returning, move_out_valid, done);
        end
        tick();
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL empty_done: done=%0b busy=%0b required 1 0", done, busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL start_in_done: busy=%0b done=%0b required 0 0", busy, done);
        end
    endtask

    task automatic test_abort();
        begin_trip();
        for (int i = 0; i < 5; i++) push_move(3'($urandom_range(0, 7)));
        abort_i = 1'b1;
        move_valid = 1'b1;
        food_found = 1'b1;
        tick();
        abort_i = 1'b0;
        move_valid = 1'b0;
        food_found = 1'b0;
        total++;
        if (busy !== 1'b0 || depth !== 6'd0 || overflow !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_explore: busy=%0b depth=%0d ovf=%0b done=%0b required 0 0 0 0",
                     busy, depth, overflow, done);
        end
        begin_trip();
        for (int i = 0; i < 33; i++) push_move(3'($urandom_range(0, 7)));
        food_found = 1'b1;
        tick();
        food_found = 1'b0;
        move_ready = 1'b1;
        tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        move_ready = 1'b0;
        total++;
        if (move_out_valid !== 1'b0 || depth !== 6'd0 || overflow !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_return: valid=%0b depth=%0d ovf=%0b busy=%0b done=%0b required 0 0 1 0 0",
                     move_out_valid, depth, overflow, busy, done);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: done=%0b busy=%0b required 0 0", done, busy);
        end
    endtask

    task automatic test_random_trips();
        int n;
        int cycles;
        for (int t = 0; t < 8; t++) begin
            begin_trip();
            cycles = $urandom_range(0, 45);
            for (int c = 0; c < cycles; c++) begin
                if ($urandom_range(0, 3) != 0) push_move(3'($urandom_range(0, 7)));
                else tick();
            end
            food_found = 1'b1;
            if ($urandom_range(0, 1) == 1) push_move(3'($urandom_range(0, 7)));
            else tick();
            food_found = 1'b0;
            total++;
            if (int'(depth) !== stk.size() || overflow !== m_ovf || returning !== 1'b1) begin
                bad++;
                $display("FAIL rand_trip%0d: depth=%0d ovf=%0b ret=%0b required %0d %0b 1",
                         t, depth, overflow, returning, stk.size(), m_ovf);
            end
            drain(n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_overflow();
        test_backpressure();
        test_same_cycle();
        test_empty_return();
        test_abort();
        test_random_trips();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
